meta_align_fifo: RTL and testbench

Metadata alignment FIFO for the IP encapsulator. It captures per-packet header metadata (IP addresses, UDP ports, payload length, destination index, flags) from the request side and packs it into one fixed 192-bit word. It holds up to DEPTH words in order, so header generation can consume them in step with the payload stream. The FIFO is first-word-fall-through (FWFT) with valid/ready handshakes on both sides. Module name: `meta_align_fifo`.

---
 rtl/meta_align_fifo.sv | 73 +++++++
 tb/tb_meta_align_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/meta_align_fifo.sv
// meta_align_fifo: FWFT FIFO packing per-packet header metadata into 192-bit words.
// Optional META_ALIGN_ERR_EN adds a sticky overflow output for pushes attempted while full.
module meta_align_fifo #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         meta_valid,
    output logic         meta_ready,
    input  logic [31:0]  meta_src_ip,
    input  logic [31:0]  meta_dst_ip,
    input  logic [15:0]  meta_src_port,
    input  logic [15:0]  meta_dst_port,
    input  logic [31:0]  meta_payload_len,
    input  logic [15:0]  meta_dst_index,
    input  logic [15:0]  meta_flags,
    output logic         meta_out_valid,
    input  logic         meta_out_ready,
    output logic [191:0] meta_out_bus,
    output logic         almost_full,
    output logic         full,
`ifdef META_ALIGN_ERR_EN
    output logic         overflow,
`endif
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [191:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] count;
    logic          w_push;
    logic          w_pop;
    logic [191:0]  w_word;

    assign w_word = {16'h0000, meta_flags, meta_payload_len, meta_dst_ip, meta_src_ip,
                     meta_dst_index, 16'h0000, meta_dst_port, meta_src_port};

    assign full           = count == CW'(DEPTH);
    assign almost_full    = count >= CW'(DEPTH - 1);
    assign empty          = count == '0;
    assign meta_ready     = !full && !rst;
    assign meta_out_valid = !empty;
    assign meta_out_bus   = empty ? '0 : r_mem[r_rd_ptr];
    assign w_push         = meta_valid && meta_ready;
    assign w_pop          = meta_out_valid && meta_out_ready;

    // Storage is left unreset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            count <= count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef META_ALIGN_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) overflow <= 1'b0;
        else if (meta_valid && full) overflow <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_meta_align_fifo.sv
// tb_meta_align_fifo: directed self-checking bench for meta_align_fifo (DEPTH=4).
module tb_meta_align_fifo;
    logic         clk = 0;
    logic         rst = 1;
    logic         meta_valid = 0;
    logic         meta_ready;
    logic [31:0]  meta_src_ip = 0;
    logic [31:0]  meta_dst_ip = 0;
    logic [15:0]  meta_src_port = 0;
    logic [15:0]  meta_dst_port = 0;
    logic [31:0]  meta_payload_len = 0;
    logic [15:0]  meta_dst_index = 0;
    logic [15:0]  meta_flags = 0;
    logic         meta_out_valid;
    logic         meta_out_ready = 0;
    logic [191:0] meta_out_bus;
    logic         almost_full;
    logic         full;
    logic         empty;
`ifdef META_ALIGN_ERR_EN
    logic         overflow;
`endif
    int checks = 0;
    int failures = 0;

    meta_align_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .meta_valid(meta_valid), .meta_ready(meta_ready),
        .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip),
        .meta_src_port(meta_src_port), .meta_dst_port(meta_dst_port),
        .meta_payload_len(meta_payload_len), .meta_dst_index(meta_dst_index),
        .meta_flags(meta_flags),
        .meta_out_valid(meta_out_valid), .meta_out_ready(meta_out_ready),
        .meta_out_bus(meta_out_bus),
        .almost_full(almost_full), .full(full),
`ifdef META_ALIGN_ERR_EN
        .overflow(overflow),
`endif
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [191:0] pack(input int n);
        logic [31:0] v;
        v = n;
        return {16'h0000, 16'h0001, 32'h100 + v, 32'h0A0000FF - v, 32'h0A000001 + v,
                v[15:0], 16'h0000, 16'h2000 + v[15:0], 16'h1000 + v[15:0]};
    endfunction

    task automatic set_meta(input int n);
        logic [31:0] v;
        v = n;
        meta_src_ip      = 32'h0A000001 + v;
        meta_dst_ip      = 32'h0A0000FF - v;
        meta_src_port    = 16'h1000 + v[15:0];
        meta_dst_port    = 16'h2000 + v[15:0];
        meta_payload_len = 32'h100 + v;
        meta_dst_index   = v[15:0];
        meta_flags       = 16'h0001;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int q[$];
        logic [7:0] pat;
        pat = 8'b0110_1011;
        step();
        check("rst_ready", meta_ready, 0);
        step();
        rst = 0;
        #1;
        check("idle_empty", empty, 1);
        check("idle_full", full, 0);
        check("idle_valid", meta_out_valid, 0);
        check("idle_ready", meta_ready, 1);
        check("idle_count", dut.count, 0);
        check("idle_bus", meta_out_bus, 0);

        for (int n = 0; n < 4; n++) begin
            set_meta(n);
            meta_valid = 1;
            step();
            check($sformatf("fill_count%0d", n), dut.count, n + 1);
            check($sformatf("fill_af%0d", n), almost_full, (n + 1 >= 3));
            check($sformatf("fill_full%0d", n), full, (n + 1 == 4));
            check($sformatf("fill_ready%0d", n), meta_ready, (n + 1 < 4));
            if (n == 0) begin
                check("first_bus", meta_out_bus,
                      192'h0000_0001_00000100_0A0000FF_0A000001_0000_0000_2000_1000);
                check("first_valid", meta_out_valid, 1);
            end
        end

        set_meta(4);
        step();
        meta_valid = 0;
        check("ovf_count", dut.count, 4);
        check("ovf_bus_stable", meta_out_bus, pack(0));
`ifdef META_ALIGN_ERR_EN
        check("ovf_flag", overflow, 1);
`endif

        e = 0;
        for (int c = 0; c < 20 && e < 4; c++) begin
            meta_out_ready = pat[c % 8];
            check($sformatf("drain_valid%0d", c), meta_out_valid, 1);
            check($sformatf("drain_bus%0d", c), meta_out_bus, pack(e));
            if (meta_out_ready) e++;
            step();
        end
        meta_out_ready = 0;
        check("drain_done", e, 4);
        check("drain_count", dut.count, 0);
        check("drain_empty", empty, 1);
        check("drain_bus0", meta_out_bus, 0);

        set_meta(10);
        meta_valid = 1;
        step();
        q.push_back(10);
        meta_out_ready = 1;
        for (int n = 11; n <= 16; n++) begin
            set_meta(n);
            check($sformatf("wrap_bus%0d", n), meta_out_bus, pack(q[0]));
            void'(q.pop_front());
            q.push_back(n);
            step();
            check($sformatf("wrap_count%0d", n), dut.count, 1);
        end
        meta_valid = 0;
        check("wrap_last", meta_out_bus, pack(16));
        step();
        meta_out_ready = 0;
        check("wrap_empty", empty, 1);

        meta_valid = 1;
        for (int n = 20; n < 23; n++) begin
            set_meta(n);
            step();
        end
        meta_valid = 0;
        check("mid_count3", dut.count, 3);
        rst = 1;
        step();
        rst = 0;
        check("mid_count0", dut.count, 0);
        check("mid_empty", empty, 1);
        check("mid_bus", meta_out_bus, 0);
`ifdef META_ALIGN_ERR_EN
        check("mid_ovf_clr", overflow, 0);
`endif
        set_meta(30);
        meta_valid = 1;
        step();
        meta_valid = 0;
        check("post_rst_bus", meta_out_bus, pack(30));
        check("post_rst_count", dut.count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
